// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: shared TAP state encoding, fixed opcodes and instruction decode.
package jtag_tap_pkg;

  // 16-state IEEE 1149.1 TAP controller
  typedef enum logic [3:0] {
    StTestLogicReset,
    StRunTestIdle,
    StSelectDrScan,
    StCaptureDr,
    StShiftDr,
    StExit1Dr,
    StPauseDr,
    StExit2Dr,
    StUpdateDr,
    StSelectIrScan,
    StCaptureIr,
    StShiftIr,
    StExit1Ir,
    StPauseIr,
    StExit2Ir,
    StUpdateIr
  } tap_state_e;

  // Widest instruction register the decode function handles
  localparam int unsigned InstMaxW  = 32;
  localparam logic [7:0]  IdcodeOp  = 8'h01;
  localparam int unsigned IdcodeLen = 32;

  typedef enum logic [1:0] {
    InstBypass,
    InstIdcode,
    InstUser
  } inst_kind_e;

  typedef struct packed {
    inst_kind_e  kind;
    logic [2:0]  chan;
  } inst_dec_t;

  // All-ones is BYPASS, 1 is IDCODE, user_base+k is channel k; anything else acts as BYPASS.
  function automatic inst_dec_t decode_inst(input logic [InstMaxW-1:0] inst,
                                            input int unsigned          ir_width,
                                            input logic [InstMaxW-1:0] user_base,
                                            input int unsigned          num_chan);
    inst_dec_t            dec;
    logic [InstMaxW-1:0]  ones;
    logic [InstMaxW-1:0]  offs;
    dec.kind = InstBypass;
    dec.chan = '0;
    ones     = '0;
    for (int unsigned i = 0; i < InstMaxW; i++) begin
      if (i < ir_width) ones[i] = 1'b1;
    end
    offs = inst - user_base;
    if (inst == ones) begin
      dec.kind = InstBypass;
    end else if (inst == 32'(IdcodeOp)) begin
      dec.kind = InstIdcode;
    end else if ((inst >= user_base) && (offs < num_chan)) begin
      dec.kind = InstUser;
      dec.chan = offs[2:0];
    end
    return dec;
  endfunction

endpackage

// File: rtl/jtag_tap_sync_pin_sync.sv
// jtag_pin_sync: multi-flop synchroniser for one JTAG pin plus rise/fall detect.
// Edge outputs are combinational from the last two synced samples, so the
// consumer acts on them at the following clk edge.
module jtag_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  // Synchroniser chain and previous-sample flop
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], pin};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync = chain_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/jtag_tap_sync.sv
// jtag_tap_sync: IEEE 1149.1 TAP controller running entirely on clk.
// tck/tms/tdi are oversampled; TAP actions fire one clk after a synced tck edge.
// Optional build macro JTAG_TAP_TRST_EN: honour the active-low trst pin.
module jtag_tap_sync
  import jtag_tap_pkg::*;
#(
  parameter int unsigned         IR_WIDTH    = 8,
  parameter int unsigned         DR_WIDTH    = 32,
  parameter int unsigned         NUM_CHAN    = 2,
  parameter logic [31:0]         IDCODE_VAL  = 32'h1000_0FFF,
  parameter logic [IR_WIDTH-1:0] USER_BASE   = IR_WIDTH'(8'h02),
  parameter int unsigned         SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tck,
  input  logic                         tms,
  input  logic                         tdi,
  input  logic                         trst,
  output logic                         tdo,
  output logic                         tdoen,
  output logic [IR_WIDTH-1:0]          tapo_inst,
  input  logic [NUM_CHAN*DR_WIDTH-1:0] chan_capt_data,
  output logic [DR_WIDTH-1:0]          chan_upd_data,
  output logic [NUM_CHAN-1:0]          chan_upd,
  output logic [NUM_CHAN-1:0]          chan_capt
);

  // One DR shift register shared by IDCODE, BYPASS and the user channels
  localparam int unsigned DrLen = (DR_WIDTH > IdcodeLen) ? DR_WIDTH : IdcodeLen;
  localparam logic [IR_WIDTH-1:0] IdcodeInst = IR_WIDTH'(IdcodeOp);

  logic tck_s, tck_rise, tck_fall;
  logic tms_s, tms_rise, tms_fall;
  logic tdi_s, tdi_rise, tdi_fall;

  jtag_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tck_sync (
    .clk  (clk),
    .reset(reset),
    .pin  (tck),
    .sync (tck_s),
    .rise (tck_rise),
    .fall (tck_fall)
  );

  jtag_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tms_sync (
    .clk  (clk),
    .reset(reset),
    .pin  (tms),
    .sync (tms_s),
    .rise (tms_rise),
    .fall (tms_fall)
  );

  jtag_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tdi_sync (
    .clk  (clk),
    .reset(reset),
    .pin  (tdi),
    .sync (tdi_s),
    .rise (tdi_rise),
    .fall (tdi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{tck_s, tms_rise, tms_fall, tdi_rise, tdi_fall};

  logic trst_rst;
`ifdef JTAG_TAP_TRST_EN
  logic trst_s, trst_rise, trst_fall;
  jtag_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_trst_sync (
    .clk  (clk),
    .reset(reset),
    .pin  (trst),
    .sync (trst_s),
    .rise (trst_rise),
    .fall (trst_fall)
  );
  logic unused_trst;
  assign unused_trst = ^{trst_rise, trst_fall};
  assign trst_rst    = ~trst_s;
`else
  logic unused_trst;
  assign unused_trst = trst;
  assign trst_rst    = 1'b0;
`endif

  logic tap_rst, rise_act, fall_act;
  assign tap_rst  = reset | trst_rst;
  // Edges are ignored while the TAP is held in reset
  assign rise_act = tck_rise & ~trst_rst;
  assign fall_act = tck_fall & ~trst_rst;

  tap_state_e            state_q, state_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_d, inst_q, inst_d;
  logic [DrLen-1:0]      dr_q, dr_d, dr_shift, capt_val;
  logic                  tdo_q, tdo_d, tdoen_q, tdoen_d;
  logic [NUM_CHAN-1:0]   capt_q, capt_d, upd_q, upd_d, chan_sel;
  logic [DR_WIDTH-1:0]   upd_data_q, upd_data_d;
  int unsigned           dr_len;
  inst_dec_t             dec;

  assign dec = decode_inst(32'(inst_q), IR_WIDTH, 32'(USER_BASE), NUM_CHAN);

  // Active DR length, capture value and channel select for the current instruction
  always_comb begin
    dr_len   = 1;
    capt_val = '0;
    chan_sel = '0;
    unique case (dec.kind)
      InstIdcode: begin
        dr_len   = IdcodeLen;
        capt_val = DrLen'(IDCODE_VAL);
      end
      InstUser: begin
        dr_len = DR_WIDTH;
        for (int unsigned k = 0; k < NUM_CHAN; k++) begin
          if (32'(dec.chan) == k) begin
            chan_sel[k] = 1'b1;
            capt_val    = DrLen'(chan_capt_data[k*DR_WIDTH +: DR_WIDTH]);
          end
        end
      end
      default: ;
    endcase
  end

  // Right shift with tdi entering at the MSB of the active-length register
  always_comb begin
    dr_shift = {1'b0, dr_q[DrLen-1:1]};
    for (int unsigned i = 0; i < DrLen; i++) begin
      if (i == dr_len - 1) dr_shift[i] = tdi_s;
    end
  end

  // TAP next-state logic, advancing only on a tck rising edge
  always_comb begin
    state_d = state_q;
    if (rise_act) begin
      unique case (state_q)
        StTestLogicReset: state_d = tms_s ? StTestLogicReset : StRunTestIdle;
        StRunTestIdle:    state_d = tms_s ? StSelectDrScan   : StRunTestIdle;
        StSelectDrScan:   state_d = tms_s ? StSelectIrScan   : StCaptureDr;
        StCaptureDr:      state_d = tms_s ? StExit1Dr        : StShiftDr;
        StShiftDr:        state_d = tms_s ? StExit1Dr        : StShiftDr;
        StExit1Dr:        state_d = tms_s ? StUpdateDr       : StPauseDr;
        StPauseDr:        state_d = tms_s ? StExit2Dr        : StPauseDr;
        StExit2Dr:        state_d = tms_s ? StUpdateDr       : StShiftDr;
        StUpdateDr:       state_d = tms_s ? StSelectDrScan   : StRunTestIdle;
        StSelectIrScan:   state_d = tms_s ? StTestLogicReset : StCaptureIr;
        StCaptureIr:      state_d = tms_s ? StExit1Ir        : StShiftIr;
        StShiftIr:        state_d = tms_s ? StExit1Ir        : StShiftIr;
        StExit1Ir:        state_d = tms_s ? StUpdateIr       : StPauseIr;
        StPauseIr:        state_d = tms_s ? StExit2Ir        : StPauseIr;
        StExit2Ir:        state_d = tms_s ? StUpdateIr       : StShiftIr;
        StUpdateIr:       state_d = tms_s ? StSelectDrScan   : StRunTestIdle;
        default:          state_d = StTestLogicReset;
      endcase
    end
  end

  // Register actions: capture/shift in-state on rise, update on entry, tdo on fall
  always_comb begin
    ir_d       = ir_q;
    dr_d       = dr_q;
    inst_d     = inst_q;
    tdo_d      = tdo_q;
    tdoen_d    = tdoen_q;
    capt_d     = '0;
    upd_d      = '0;
    upd_data_d = upd_data_q;
    if (state_q == StTestLogicReset) inst_d = IdcodeInst;
    if (rise_act) begin
      case (state_q)
        StCaptureIr: ir_d = IR_WIDTH'(2'b01);
        StShiftIr:   ir_d = {tdi_s, ir_q[IR_WIDTH-1:1]};
        StCaptureDr: begin
          dr_d   = capt_val;
          capt_d = chan_sel;
        end
        StShiftDr:   dr_d = dr_shift;
        default: ;
      endcase
      if (state_d == StUpdateIr) inst_d = ir_q;
      if (state_d == StUpdateDr) begin
        upd_d = chan_sel;
        if (|chan_sel) upd_data_d = dr_q[DR_WIDTH-1:0];
      end
    end
    if (fall_act) begin
      tdoen_d = (state_q == StShiftIr) || (state_q == StShiftDr);
      if (state_q == StShiftIr) tdo_d = ir_q[0];
      else if (state_q == StShiftDr) tdo_d = dr_q[0];
    end
  end

  // TAP state and shift registers, also cleared by trst when enabled
  always_ff @(posedge clk) begin
    if (tap_rst) begin
      state_q <= StTestLogicReset;
      ir_q    <= '0;
      dr_q    <= '0;
      inst_q  <= IdcodeInst;
      tdo_q   <= 1'b0;
      tdoen_q <= 1'b0;
      capt_q  <= '0;
      upd_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      dr_q    <= dr_d;
      inst_q  <= inst_d;
      tdo_q   <= tdo_d;
      tdoen_q <= tdoen_d;
      capt_q  <= capt_d;
      upd_q   <= upd_d;
    end
  end

  // Update data survives trst; only the system reset clears it
  always_ff @(posedge clk) begin
    if (reset) upd_data_q <= '0;
    else       upd_data_q <= upd_data_d;
  end

  assign tdo           = tdo_q;
  assign tdoen         = tdoen_q;
  assign tapo_inst     = inst_q;
  assign chan_capt     = capt_q;
  assign chan_upd      = upd_q;
  assign chan_upd_data = upd_data_q;

endmodule

// File: tb/tb_jtag_tap_sync.sv
// tb_jtag_tap_sync: drives JTAG scans through the oversampled pins and checks
// against a scan-level model (capture value followed by tdi bits as one stream).
module tb_jtag_tap_sync;
  localparam int IRW = 8;
  localparam int DRW = 32;
  localparam int NCH = 2;
  localparam int PH  = 6;
  localparam logic [31:0] IDCODE = 32'h1000_0FFF;

  logic clk = 1'b0;
  logic reset, tck, tms, tdi, trst, tdo, tdoen;
  logic [IRW-1:0]     tapo_inst;
  logic [NCH*DRW-1:0] chan_capt_data;
  logic [DRW-1:0]     chan_upd_data;
  logic [NCH-1:0]     chan_upd, chan_capt;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]     mdl_inst;
  logic [NCH-1:0] exp_capt_mask, exp_upd_mask;
  logic [DRW-1:0] exp_upd_data, mdl_upd_data;
  int             capt_seen, upd_seen;

  always #5 clk = ~clk;

  jtag_tap_sync dut (
    .clk           (clk),
    .reset         (reset),
    .tck           (tck),
    .tms           (tms),
    .tdi           (tdi),
    .trst          (trst),
    .tdo           (tdo),
    .tdoen         (tdoen),
    .tapo_inst     (tapo_inst),
    .chan_capt_data(chan_capt_data),
    .chan_upd_data (chan_upd_data),
    .chan_upd      (chan_upd),
    .chan_capt     (chan_capt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // DR length, capture value and user channel (-1 if none) for an opcode
  task automatic mdl_dr(input logic [7:0] inst, output int len, output logic [63:0] capt,
                        output int chan);
    chan = -1;
    len  = 1;
    capt = '0;
    if (inst == 8'h01) begin
      len  = 32;
      capt = 64'(IDCODE);
    end else if (inst == 8'h02 || inst == 8'h03) begin
      chan = int'(inst) - 2;
      len  = DRW;
      capt = 64'(chan_capt_data[chan*DRW +: DRW]);
    end
  endtask

  // Strobe and update-data monitor, every clk
  always @(negedge clk) begin
    if (reset) begin
      mdl_upd_data = '0;
    end else begin
      if (chan_capt != '0) begin
        capt_seen++;
        check("chan_capt", 64'(chan_capt), 64'(exp_capt_mask));
      end
      if (chan_upd != '0) begin
        upd_seen++;
        check("chan_upd", 64'(chan_upd), 64'(exp_upd_mask));
        check("chan_upd_data", 64'(chan_upd_data), 64'(exp_upd_data));
        mdl_upd_data = exp_upd_data;
      end else begin
        check("upd_data_hold", 64'(chan_upd_data), 64'(mdl_upd_data));
      end
    end
  end

  // One full tck cycle; returns tdo/tdoen after the falling edge has acted
  task automatic tck_pulse(input bit tms_v, input bit tdi_v, output logic tdo_s,
                           output logic en_s);
    tms = tms_v;
    tdi = tdi_v;
    @(posedge clk); #1;
    tck = 1'b1;
    repeat (PH) @(posedge clk);
    #1;
    tck = 1'b0;
    repeat (PH) @(posedge clk);
    #1;
    tdo_s = tdo;
    en_s  = tdoen;
  endtask

  task automatic to_idle();
    logic o, e;
    for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0, o, e);
    tck_pulse(1'b0, 1'b0, o, e);
  endtask

  // Full IR or DR scan of n bits from Run-Test/Idle back to Run-Test/Idle
  task automatic scan(input bit is_ir, input int n, input logic [63:0] din_raw,
                      output logic [63:0] dout);
    int           len, chan;
    logic [63:0]  capt, din, exp_out, nreg;
    logic [127:0] s;
    logic         o, e;
    if (is_ir) begin
      len  = IRW;
      capt = 64'h1;
      chan = -1;
    end else begin
      mdl_dr(mdl_inst, len, capt, chan);
    end
    din     = din_raw & mask(n);
    s       = (128'(din) << len) | 128'(capt);
    exp_out = s[63:0] & mask(n);
    nreg    = 64'(s >> n) & mask(len);
    exp_capt_mask = (chan >= 0) ? NCH'(1 << chan) : '0;
    exp_upd_mask  = exp_capt_mask;
    exp_upd_data  = nreg[DRW-1:0];
    capt_seen = 0;
    upd_seen  = 0;
    dout = '0;
    tck_pulse(1'b1, 1'($urandom), o, e);
    if (is_ir) tck_pulse(1'b1, 1'($urandom), o, e);
    tck_pulse(1'b0, 1'($urandom), o, e);
    tck_pulse(1'b0, 1'($urandom), o, e);
    check("tdoen_shift", 64'(e), 64'd1);
    dout[0] = o;
    for (int k = 0; k < n; k++) begin
      tck_pulse(k == n - 1, din[k], o, e);
      if (k < n - 1) begin
        check("tdoen_shift", 64'(e), 64'd1);
        dout[k+1] = o;
      end else begin
        check("tdoen_exit", 64'(e), 64'd0);
      end
    end
    tck_pulse(1'b1, 1'($urandom), o, e);
    tck_pulse(1'b0, 1'($urandom), o, e);
    check("tdoen_idle", 64'(e), 64'd0);
    check(is_ir ? "ir_tdo" : "dr_tdo", dout, exp_out);
    if (is_ir) begin
      mdl_inst = nreg[7:0];
      check("tapo_inst", 64'(tapo_inst), 64'(mdl_inst));
    end
    check("capt_count", 64'(capt_seen), (chan >= 0) ? 64'd1 : 64'd0);
    check("upd_count", 64'(upd_seen), (chan >= 0) ? 64'd1 : 64'd0);
    exp_capt_mask = '0;
    exp_upd_mask  = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] dout;
    logic [7:0]  op;
    logic        o, e;
    int          n;
    reset = 1'b1;
    tck = 1'b0;
    tms = 1'b1;
    tdi = 1'b0;
    trst = 1'b1;
    chan_capt_data = {$urandom, $urandom};
    exp_capt_mask = '0;
    exp_upd_mask  = '0;
    exp_upd_data  = '0;
    mdl_upd_data  = '0;
    mdl_inst      = 8'h01;
    capt_seen = 0;
    upd_seen  = 0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_tdo", 64'(tdo), 64'd0);
    check("rst_tdoen", 64'(tdoen), 64'd0);
    check("rst_tapo_inst", 64'(tapo_inst), 64'h01);
    check("rst_chan_upd", 64'(chan_upd), 64'd0);
    check("rst_chan_capt", 64'(chan_capt), 64'd0);
    check("rst_upd_data", 64'(chan_upd_data), 64'd0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    to_idle();
    check("idle_tapo_inst", 64'(tapo_inst), 64'h01);

    // IDCODE readout
    scan(1'b0, 32, {$urandom, $urandom}, dout);
    check("idcode_literal", dout, 64'h1000_0FFF);

    // Channel 0 capture/update
    scan(1'b1, 8, 64'h02, dout);
    chan_capt_data[31:0] = 32'hDEAD_BEEF;
    scan(1'b0, 32, 64'h1234_5678, dout);
    check("chan0_tdo_literal", dout, 64'hDEAD_BEEF);
    check("chan0_upd_literal", 64'(chan_upd_data), 64'h1234_5678);

    // Channel 1 only
    scan(1'b1, 8, 64'h03, dout);
    scan(1'b0, 32, 64'hCAFE_F00D, dout);
    check("chan1_upd_literal", 64'(chan_upd_data), 64'hCAFE_F00D);

    // BYPASS and an unmapped opcode
    scan(1'b1, 8, 64'hFF, dout);
    scan(1'b0, 8, 64'hA5, dout);
    check("bypass_literal", dout, 64'h4A);
    scan(1'b1, 8, 64'h7E, dout);
    scan(1'b0, 8, 64'hA5, dout);
    check("unmapped_literal", dout, 64'h4A);

    // Randomised scans
    for (int t = 0; t < 25; t++) begin
      chan_capt_data = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0:       op = 8'h01;
        1:       op = 8'h02;
        2:       op = 8'h03;
        3:       op = 8'hFF;
        default: op = 8'($urandom);
      endcase
      if (t % 4 == 3) scan(1'b1, $urandom_range(5, 12), {$urandom, $urandom}, dout);
      else            scan(1'b1, 8, 64'(op), dout);
      n = $urandom_range(1, 40);
      scan(1'b0, n, {$urandom, $urandom}, dout);
    end

    // Reset in the middle of a channel 0 shift
    scan(1'b1, 8, 64'h02, dout);
    exp_capt_mask = 2'b01;
    exp_upd_mask  = '0;
    capt_seen = 0;
    upd_seen  = 0;
    tck_pulse(1'b1, 1'b0, o, e);
    tck_pulse(1'b0, 1'b0, o, e);
    tck_pulse(1'b0, 1'b0, o, e);
    for (int k = 0; k < 5; k++) tck_pulse(1'b0, 1'($urandom), o, e);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mdl_inst = 8'h01;
    check("midrst_tapo_inst", 64'(tapo_inst), 64'h01);
    check("midrst_tdoen", 64'(tdoen), 64'd0);
    to_idle();
    check("midrst_upd_count", 64'(upd_seen), 64'd0);
    check("midrst_capt_count", 64'(capt_seen), 64'd1);
    exp_capt_mask = '0;
    scan(1'b0, 32, {$urandom, $urandom}, dout);
    check("midrst_idcode", dout, 64'h1000_0FFF);

    // trst pulse during SHIFT_IR (loading 8'h02 over a previous 8'h03)
    scan(1'b1, 8, 64'h03, dout);
    op = 8'h02;
    tck_pulse(1'b1, 1'b0, o, e);
    tck_pulse(1'b1, 1'b0, o, e);
    tck_pulse(1'b0, 1'b0, o, e);
    tck_pulse(1'b0, 1'b0, o, e);
    for (int k = 0; k < 3; k++) tck_pulse(1'b0, op[k], o, e);
    trst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
`ifdef JTAG_TAP_TRST_EN
    check("trst_tapo_inst", 64'(tapo_inst), 64'h01);
    check("trst_tdoen", 64'(tdoen), 64'd0);
    trst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    mdl_inst = 8'h01;
    tck_pulse(1'b0, 1'b0, o, e);
    scan(1'b0, 32, {$urandom, $urandom}, dout);
    check("trst_idcode", dout, 64'h1000_0FFF);
`else
    trst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("trst_ignored_tdoen", 64'(tdoen), 64'd1);
    for (int k = 3; k < 8; k++) tck_pulse(k == 7, op[k], o, e);
    tck_pulse(1'b1, 1'b0, o, e);
    tck_pulse(1'b0, 1'b0, o, e);
    check("trst_ignored_tapo_inst", 64'(tapo_inst), 64'h02);
    mdl_inst = 8'h02;
    scan(1'b0, 32, 64'h0BAD_F00D, dout);
    check("trst_ignored_upd", 64'(chan_upd_data), 64'h0BAD_F00D);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
